// File: rtl/decoder_pkg.sv
// ---------------------------------------------------------------------------
// decoder_pkg
// Shared definitions for the decoder_scan family.
//   dec_mode_e   : operating mode of the decoder (direct decode or scan walk)
//   dwell_cnt_w  : width of a counter that must count 0..dwell-1, never 0 bits
// ---------------------------------------------------------------------------
package decoder_pkg;

    // Mode input encoding: 0 decodes sel directly, 1 runs the scan sequencer.
    typedef enum logic {
        DEC_MODE_DIRECT = 1'b0,
        DEC_MODE_SCAN   = 1'b1
    } dec_mode_e;

    // A dwell of 1 still needs a 1-bit counter so the vector is never empty.
    function automatic int dwell_cnt_w(input int dwell);
        return (dwell > 1) ? $clog2(dwell) : 1;
    endfunction

endpackage

// File: rtl/decoder_onehot.sv
// ---------------------------------------------------------------------------
// decoder_onehot
// Purely combinational one-hot line decoder.
//   en  : when low every output line is forced low
//   in  : line index to assert
//   d   : OUT_N output lines; all-zero when disabled or when in >= OUT_N
// ---------------------------------------------------------------------------
module decoder_onehot #(
    parameter int SEL_W = 5,
    parameter int OUT_N = 32
) (
    input  logic             en,
    input  logic [SEL_W-1:0] in,
    output logic [OUT_N-1:0] d
);

    // Compare against every legal line number; an index beyond the last
    // line simply matches nothing, which gives the all-zero result for free.
    always_comb begin
        d = '0;
        for (int i = 0; i < OUT_N; i++) begin
            if (en && (in == SEL_W'(i))) begin
                d[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/decoder_scan.sv
// ---------------------------------------------------------------------------
// decoder_scan
// Registered N-to-M line decoder with a built-in scan sequencer.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   en    : block enable; when low d and wrap clear, everything else freezes
//   mode  : 0 = direct decode of sel, 1 = scan through all lines
//   load  : scan mode only, jumps the scan index to sel
//   sel   : requested line index
//   d     : registered one-hot output lines
//   idx   : registered current index
//   wrap  : one-cycle pulse when the scan returns from the last line to 0
//   oor   : registered flag, last accepted sel was >= OUT_N
// ---------------------------------------------------------------------------
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int SEL_W = 5,
    parameter int OUT_N = 32,
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic             load,
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_N-1:0] d,
    output logic [SEL_W-1:0] idx,
    output logic             wrap,
    output logic             oor
);

    localparam int               CNT_W     = dwell_cnt_w(DWELL);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(OUT_N - 1);
    localparam logic [SEL_W:0]   OUT_N_EXT = (SEL_W + 1)'(OUT_N);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [SEL_W-1:0] idx_nxt;
    logic [SEL_W-1:0] scan_base;
    logic [OUT_N-1:0] d_nxt;
    logic             wrap_nxt;
    logic             oor_nxt;
    logic             sel_oor;
    logic             idx_oor;
    dec_mode_e        mode_q;
    dec_mode_e        mode_nxt;

    // Range checks are done one bit wider so OUT_N == 2**SEL_W still works.
    assign sel_oor = ({1'b0, sel} >= OUT_N_EXT);
    assign idx_oor = ({1'b0, idx} >= OUT_N_EXT);

    // An out-of-range index can only be left over from direct mode; the scan
    // must never sit on it, so it restarts from line 0 instead.
    assign scan_base = idx_oor ? '0 : idx;

    // Next-state logic. mode_q remembers the mode of the last enabled cycle so
    // the first scan cycle after direct mode (or after reset) starts a fresh
    // dwell instead of counting, giving the start line a full dwell period.
    always_comb begin
        idx_nxt  = idx;
        cnt_nxt  = cnt;
        wrap_nxt = 1'b0;
        oor_nxt  = oor;
        mode_nxt = mode_q;
        if (en) begin
            mode_nxt = dec_mode_e'(mode);
            if (mode == DEC_MODE_DIRECT) begin
                idx_nxt = sel;
                oor_nxt = sel_oor;
                cnt_nxt = '0;
            end else if (load) begin
                idx_nxt = sel_oor ? '0 : sel;
                oor_nxt = sel_oor;
                cnt_nxt = '0;
            end else if (mode_q != DEC_MODE_SCAN) begin
                idx_nxt = scan_base;
                cnt_nxt = '0;
            end else if (cnt == CNT_LAST) begin
                cnt_nxt = '0;
                if (idx == LAST_IDX) begin
                    idx_nxt  = '0;
                    wrap_nxt = 1'b1;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end else begin
                cnt_nxt = cnt + 1'b1;
                idx_nxt = scan_base;
            end
        end
    end

    // The output lines are always the decode of the index about to be
    // registered; the decoder itself blanks them when disabled or out of range.
    decoder_onehot #(
        .SEL_W (SEL_W),
        .OUT_N (OUT_N)
    ) u_onehot (
        .en (en),
        .in (idx_nxt),
        .d  (d_nxt)
    );

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d      <= '0;
            idx    <= '0;
            wrap   <= 1'b0;
            oor    <= 1'b0;
            cnt    <= '0;
            mode_q <= DEC_MODE_DIRECT;
        end else begin
            d      <= d_nxt;
            idx    <= idx_nxt;
            wrap   <= wrap_nxt;
            oor    <= oor_nxt;
            cnt    <= cnt_nxt;
            mode_q <= mode_nxt;
        end
    end

endmodule
